cache_setassoc_param: RTL and testbench

- Parametrised, blocking, write-back, write-allocate set-associative cache with tree-PLRU replacement.
- Sits between a 32-bit CPU-side port (ufp_*) and a line-wide memory port (dfp_*).
- Generalises the fixed 4-way cache: WAYS, SETS and LINE_BYTES are configurable; adds byte-masked writes and invalid-way-first victim selection.

---
 rtl/cache_setassoc_param.sv | 204 ++++++++++++++++++++
 tb/tb_cache_setassoc_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_setassoc_param.sv
// Blocking write-back, write-allocate set-associative cache with tree-PLRU replacement,
// a 32-bit CPU-side port and a line-wide memory-side port.
module cache_setassoc_param #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             ufp_addr,
  input  logic [3:0]              ufp_rmask,
  input  logic [3:0]              ufp_wmask,
  input  logic [31:0]             ufp_wdata,
  output logic [31:0]             ufp_rdata,
  output logic                    ufp_resp,
  output logic [31:0]             dfp_addr,
  output logic                    dfp_read,
  output logic                    dfp_write,
  output logic [8*LINE_BYTES-1:0] dfp_wdata,
  input  logic [8*LINE_BYTES-1:0] dfp_rdata,
  input  logic                    dfp_resp
);
  localparam int unsigned LINE_BITS = 8 * LINE_BYTES;
  localparam int unsigned OFF       = $clog2(LINE_BYTES);
  localparam int unsigned IDX       = $clog2(SETS);
  localparam int unsigned TAG       = 32 - OFF - IDX;
  localparam int unsigned WW        = $clog2(WAYS);
  localparam int unsigned IDXW      = (IDX == 0) ? 1 : IDX;
  localparam int unsigned WORDS     = LINE_BYTES / 4;
  localparam int unsigned WSW       = OFF - 2;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t          state_q;
  logic [31:2]     addr_q;
  logic [3:0]      wmask_q;
  logic [31:0]     wdata_q;
  logic [WW-1:0]   victim_q;
  logic            dfp_read_q;
  logic            dfp_write_q;
  logic [31:0]     dfp_addr_q;

  logic [LINE_BITS-1:0] data_q  [SETS][WAYS];
  logic [TAG-1:0]       tag_q   [SETS][WAYS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      dirty_q [SETS];
  logic [WAYS-2:0]      plru_q  [SETS];

  logic                 unused_addr_bits;
  logic [IDXW-1:0]      idx;
  logic [TAG-1:0]       req_tag;
  logic [WSW-1:0]       wsel;
  logic                 is_write;
  logic [WAYS-1:0]      hit_vec;
  logic                 hit;
  logic [WW-1:0]        hit_way;
  logic [WW-1:0]        plru_way;
  logic [WW-1:0]        victim;
  logic [LINE_BITS-1:0] hit_line;
  logic [LINE_BITS-1:0] merged_line;
  logic [31:0]          hit_word;
  logic [WAYS-2:0]      plru_cur;
  logic [WAYS-2:0]      plru_upd;
  logic [31:0]          fill_addr;
  logic [31:0]          wb_addr;

  assign unused_addr_bits = ^ufp_addr[1:0];
  assign idx       = (IDX == 0) ? '0 : IDXW'(addr_q[31:OFF]);
  assign req_tag   = addr_q[31:OFF+IDX];
  assign wsel      = addr_q[OFF-1:2];
  assign is_write  = |wmask_q;
  assign fill_addr = {addr_q[31:OFF], {OFF{1'b0}}};
  assign wb_addr   = (32'(tag_q[idx][victim]) << (OFF + IDX)) | (32'(idx) << OFF);

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == req_tag);
      if (hit_vec[w]) hit_way = WW'(w);
    end
    hit = |hit_vec;
  end

  // Read word and byte-merged line are both taken from the hit way, so a
  // combined read/write returns the word as it was before the merge.
  always_comb begin
    hit_line    = data_q[idx][hit_way];
    hit_word    = '0;
    merged_line = hit_line;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (wsel == WSW'(i)) begin
        hit_word = hit_line[32*i +: 32];
        for (int unsigned b = 0; b < 4; b++) begin
          if (wmask_q[b]) merged_line[32*i+8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    int unsigned node;
    plru_cur = plru_q[idx];
    node = 0;
    for (int unsigned l = 0; l < WW; l++) begin
      node = 2 * node + 1 + (plru_cur[node] ? 1 : 0);
    end
    plru_way = WW'(node - (WAYS - 1));
    plru_upd = plru_cur;
    node = 0;
    for (int unsigned l = 0; l < WW; l++) begin
      plru_upd[node] = ~hit_way[WW-1-l];
      node = 2 * node + 1 + (hit_way[WW-1-l] ? 1 : 0);
    end
    // Scanning downwards leaves the lowest-index invalid way as the victim.
    victim = plru_way;
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!valid_q[idx][w-1]) victim = WW'(w - 1);
    end
  end

  assign ufp_resp  = (state_q == COMPARE) && hit;
  assign ufp_rdata = ufp_resp ? hit_word : '0;
  assign dfp_read  = dfp_read_q;
  assign dfp_write = dfp_write_q;
  assign dfp_addr  = dfp_addr_q;
  assign dfp_wdata = data_q[idx][victim_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      victim_q    <= '0;
      dfp_read_q  <= 1'b0;
      dfp_write_q <= 1'b0;
      dfp_addr_q  <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if ((|ufp_rmask) || (|ufp_wmask)) begin
            addr_q  <= ufp_addr[31:2];
            wmask_q <= ufp_wmask;
            wdata_q <= ufp_wdata;
            state_q <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (is_write) dirty_q[idx][hit_way] <= 1'b1;
            plru_q[idx] <= plru_upd;
            state_q     <= IDLE;
          end else begin
            victim_q <= victim;
            if (dirty_q[idx][victim]) begin
              dfp_write_q <= 1'b1;
              dfp_addr_q  <= wb_addr;
              state_q     <= WRITEBACK;
            end else begin
              dfp_read_q <= 1'b1;
              dfp_addr_q <= fill_addr;
              state_q    <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (dfp_resp) begin
            dirty_q[idx][victim_q] <= 1'b0;
            dfp_write_q <= 1'b0;
            dfp_read_q  <= 1'b1;
            dfp_addr_q  <= fill_addr;
            state_q     <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (dfp_resp) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            dfp_read_q <= 1'b0;
            dfp_addr_q <= '0;
            state_q    <= COMPARE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ALLOCATE && dfp_resp) begin
      data_q[idx][victim_q] <= dfp_rdata;
      tag_q[idx][victim_q]  <= req_tag;
    end else if (state_q == COMPARE && hit && is_write) begin
      data_q[idx][hit_way] <= merged_line;
    end
  end

endmodule

// File: tb/tb_cache_setassoc_param.sv
// Directed bench for cache_setassoc_param: a driver queues expected read data,
// a monitor pops it on each ufp_resp, and a memory model logs line traffic.
module tb_cache_setassoc_param;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic [3:0]   ufp_wmask;
  logic [31:0]  ufp_wdata;
  logic [31:0]  ufp_rdata;
  logic         ufp_resp;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;

  always #5 clk = ~clk;

  cache_setassoc_param #(.WAYS(4), .SETS(16), .LINE_BYTES(32)) dut (
    .clk(clk), .rst(rst),
    .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask), .ufp_wdata(ufp_wdata),
    .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
  );

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [31:0]  exp_q[$];
  txn_t         log_q[$];
  logic [255:0] mem [logic [31:0]];
  int unsigned  mem_delay = 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [255:0] fill(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = a + 32'(4 * i);
    return l;
  endfunction

  // Memory model: answers mem_delay cycles after first seeing a request.
  initial begin
    int unsigned wcnt;
    logic        busy;
    logic [31:0] held;
    txn_t        t;
    wcnt = 0; busy = 1'b0; held = '0;
    dfp_resp = 1'b0; dfp_rdata = '0;
    forever begin
      @(negedge clk);
      dfp_resp = 1'b0;
      if (rst) begin
        wcnt = 0; busy = 1'b0;
      end else if (dfp_read || dfp_write) begin
        check("dfp_exclusive", dfp_read & dfp_write, 0);
        if (!busy) begin
          busy = 1'b1; held = dfp_addr;
        end else begin
          check("dfp_addr_stable", dfp_addr, held);
        end
        if (wcnt >= mem_delay) begin
          t.wr = dfp_write; t.addr = dfp_addr; t.data = dfp_wdata;
          log_q.push_back(t);
          if (dfp_write) mem[dfp_addr] = dfp_wdata;
          else dfp_rdata = fill(dfp_addr);
          dfp_resp = 1'b1;
          wcnt = 0; busy = 1'b0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0; busy = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (ufp_resp) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_resp: got rdata %h with nothing expected", ufp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("ufp_rdata", ufp_rdata, e);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; ufp_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ufp_resp", ufp_resp, 0);
    check("rst_ufp_rdata", ufp_rdata, 0);
    check("rst_dfp_rw", {dfp_read, dfp_write}, 0);
    check("rst_dfp_addr", dfp_addr, 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_req(input string name, input logic [31:0] a, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd,
                        input logic [31:0] expd, input int lat);
    int cyc;
    log_q.delete();
    exp_q.push_back(expd);
    @(negedge clk);
    ufp_addr = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ufp_resp && cyc < 300);
    if (!ufp_resp) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: no ufp_resp after %0d cycles", name, cyc);
      exp_q.delete();
    end else begin
      check({name, "_latency"}, cyc, lat);
    end
    ufp_rmask = '0; ufp_wmask = '0;
  endtask

  task automatic check_count(input string name, input int n);
    check({name, "_dfp_count"}, log_q.size(), n);
  endtask

  task automatic check_txn(input string name, input int k, input logic wr, input logic [31:0] a);
    if (log_q.size() <= k) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got no dfp transaction %0d, required one", name, k);
    end else begin
      check({name, "_kind"}, log_q[k].wr, wr);
      check({name, "_addr"}, log_q[k].addr, a);
    end
  endtask

  initial begin
    logic [255:0] wb_line;
    logic [31:0]  fills [4];
    fills[0] = 32'h000; fills[1] = 32'h200; fills[2] = 32'h400; fills[3] = 32'h600;

    do_reset();
    do_req("t1_rd4", 32'h4, 4'hF, 4'h0, 32'h0, 32'h4, 4);
    check_count("t1_rd4", 1);
    check_txn("t1_rd4_t0", 0, 1'b0, 32'h0);
    do_req("t1_rd8", 32'h8, 4'hF, 4'h0, 32'h0, 32'h8, 1);
    check_count("t1_rd8", 0);

    do_req("t2_wr", 32'h0, 4'h0, 4'b0011, 32'hDEADBEEF, 32'h0, 1);
    check_count("t2_wr", 0);
    do_req("t2_rd", 32'h0, 4'hF, 4'h0, 32'h0, 32'h0000BEEF, 1);
    check_count("t2_rd", 0);

    mem_delay = 5;
    do_req("t5_slow", 32'h1000, 4'hF, 4'h0, 32'h0, 32'h1000, 8);
    check_count("t5_slow", 1);
    check_txn("t5_slow_t0", 0, 1'b0, 32'h1000);
    mem_delay = 1;

    mem_delay = 50;
    @(negedge clk);
    ufp_addr = 32'h2000; ufp_rmask = 4'hF;
    for (int i = 0; i < 20 && !dfp_read; i++) @(negedge clk);
    check("t6_read_seen", dfp_read, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_read", dfp_read, 0);
    check("t6_async_resp", ufp_resp, 0);
    ufp_rmask = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_delay = 1;
    do_req("t6_rd0", 32'h0, 4'hF, 4'h0, 32'h0, 32'h0, 4);
    check_txn("t6_rd0_t0", 0, 1'b0, 32'h0);

    do_reset();
    for (int i = 0; i < 4; i++) do_req("t3_fill", fills[i], 4'hF, 4'h0, 32'h0, fills[i], 4);
    do_req("t3_hit200", 32'h200, 4'hF, 4'h0, 32'h0, 32'h200, 1);
    do_req("t3_rd800", 32'h800, 4'hF, 4'h0, 32'h0, 32'h800, 4);
    check_count("t3_rd800", 1);
    check_txn("t3_rd800_t0", 0, 1'b0, 32'h800);
    do_req("t3_rehit200", 32'h200, 4'hF, 4'h0, 32'h0, 32'h200, 1);
    check_count("t3_rehit200", 0);
    do_req("t3_miss400", 32'h400, 4'hF, 4'h0, 32'h0, 32'h400, 4);
    check_txn("t3_miss400_t0", 0, 1'b0, 32'h400);

    do_reset();
    for (int i = 0; i < 4; i++) do_req("t4_fill", fills[i], 4'hF, 4'h0, 32'h0, fills[i], 4);
    do_req("t4_wr804", 32'h804, 4'h0, 4'hF, 32'h11223344, 32'h804, 4);
    check_count("t4_wr804", 1);
    check_txn("t4_wr804_t0", 0, 1'b0, 32'h800);
    for (int i = 1; i < 4; i++) do_req("t4_touch", fills[i], 4'hF, 4'h0, 32'h0, fills[i], 1);
    do_req("t4_rdA00", 32'hA00, 4'hF, 4'h0, 32'h0, 32'hA00, 6);
    check_count("t4_rdA00", 2);
    check_txn("t4_rdA00_t0", 0, 1'b1, 32'h800);
    check_txn("t4_rdA00_t1", 1, 1'b0, 32'hA00);
    for (int i = 0; i < 8; i++) wb_line[i*32 +: 32] = 32'h800 + 32'(4 * i);
    wb_line[63:32] = 32'h11223344;
    if (log_q.size() > 0) check("t4_wb_line", log_q[0].data, wb_line);
    do_req("t4_rd804", 32'h804, 4'hF, 4'h0, 32'h0, 32'h11223344, 4);
    check_txn("t4_rd804_t0", 0, 1'b0, 32'h800);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
